ieeedrv_sd_arb: RTL and testbench
=================================

# ieeedrv_sd_arb

Round-robin arbiter that shares the single MiSTer SD block interface (sd_lba/sd_blk_cnt/sd_rd/sd_wr/sd_ack/sd_buff_wr) between NREQ track-buffer requesters, e.g. the sub-drives of one or more ieeedrv track loaders. It sits between the drive instances and the top-level SD ports. It latches a winner's LBA and block count, runs exactly one SD transaction for it, routes the acknowledge and buffer write strobe back to that requester only, and recovers from a host that never acknowledges.

## Interface
Parameters:
- NREQ, 2, number of requesters (≥2)
- TIMEOUT_W, 24, width of the no-ack timeout counter; timeout = 2^TIMEOUT_W−1 cycles
- IW, $clog2(NREQ), index width (derived)

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- req_lba  in  32×NREQ  per-requester start LBA
- req_blk_cnt  in  6×NREQ  per-requester block count minus one
- req_rd  in  NREQ  read request, level, held until own req_ack
- req_wr  in  NREQ  write request, level, held until own req_ack
- req_ack  out  NREQ  per-requester acknowledge
- req_buff_wr  out  NREQ  sd_buff_wr routed to granted requester
- req_err  out  NREQ  one-cycle pulse: request timed out
- sd_lba  out  32  to host
- sd_blk_cnt  out  6  to host
- sd_rd  out  1  to host
- sd_wr  out  1  to host
- sd_ack  in  1  from host, high during transfer
- sd_buff_wr  in  1  from host
- grant  out  IW  index of current or last owner
- busy  out  1  high in every state but IDLE

## Operation
- States: IDLE, ISSUE, XFER, DONE.
- IDLE: pending[i] = req_rd[i] | req_wr[i]. Winner = first pending index scanning last+1, last+2 … wrapping mod NREQ, ending at last. On a winner: grant←winner, last←winner, latch sd_lba/sd_blk_cnt from winner, assert sd_wr if req_wr[winner], else sd_rd. Write wins over read on the same requester. → ISSUE. No pending: stay.
- ISSUE: wait for sd_ack=1 → XFER. sd_rd/sd_wr stay asserted until that cycle. If the owner drops both req_rd and req_wr before ack, abort: sd_rd/sd_wr←0 → DONE, no req_ack. If the timeout counter saturates: sd_rd/sd_wr←0, pulse req_err[grant] → DONE.
- XFER: sd_ack=1 holds. sd_ack falling → DONE.
- DONE: one idle cycle → IDLE. Guarantees sd_rd/sd_wr low for at least 2 cycles between transactions.
- req_ack[i] = sd_ack & busy & (grant==i). Combinational, so the requester sees ack in the same cycle as the host.
- req_buff_wr[i] = sd_buff_wr & (state==XFER) & (grant==i). Others always 0.
- Latched sd_lba/sd_blk_cnt do not change between IDLE exit and DONE, even if req_lba changes.
- Timeout counter clears on IDLE→ISSUE and increments in ISSUE only. XFER has no timeout.

## Timing
- Reset (async assert): state=IDLE. sd_rd, sd_wr, sd_lba, sd_blk_cnt, req_err, grant, busy all 0. last=NREQ−1, so requester 0 has first priority. Counter=0. req_ack and req_buff_wr are 0 as a result.
- Deassertion is used as-is. The integrator synchronises release.
- Latency: request high at edge N (IDLE) → sd_rd/sd_wr and the latched LBA visible after edge N+1.
- Back-to-back: sd_ack falls at edge M → DONE after M → IDLE after M+1 → next sd_rd after M+2.
- Simultaneous requests in IDLE: only round-robin order decides. A requester asserting again right after service goes last if others are pending.
- Abort and timeout in the same cycle: abort takes precedence, no req_err.
- sd_ack already high on IDLE exit (host glitch): ISSUE moves to XFER on the next edge.
- Reset mid-transaction: sd_rd/sd_wr drop immediately. The host is expected to terminate.

## Test plan
- Single read: req_rd[1]=1, req_lba[1]=0x1D, req_blk_cnt[1]=28. Expect after 1 cycle sd_rd=1, sd_lba=0x1D, sd_blk_cnt=28, grant=1. Host ack 4 cycles with 3 sd_buff_wr pulses. Expect req_ack[1] mirrors ack and req_buff_wr[1] gets 3 pulses while others get 0. sd_rd=0 from the cycle after ack rises.
- Contention, NREQ=4: all four req_rd held, each released on own ack. Expect grant order 0,1,2,3, and 2-cycle sd_rd-low gaps between transactions.
- Fairness: requester 0 re-requests immediately after its ack, while 2 is pending. Expect 2 served before 0 again.
- Read+write on the same requester: req_rd[0]=req_wr[0]=1. Expect sd_wr=1, sd_rd=0.
- Abort: req_rd[3] dropped 5 cycles into ISSUE with no ack. Expect sd_rd=0 next cycle, no req_ack[3], no req_err, busy=0 two cycles later.
- Timeout with TIMEOUT_W=4: no ack for 15 cycles. Expect req_err[grant] one-cycle pulse and sd_rd=0. Then assert reset_n=0 mid-XFER of a new request and check that all outputs go 0 asynchronously.

Source files
------------

// File: rtl/ieeedrv_sd_arb.sv
// Round-robin arbiter that shares one MiSTer SD block interface between NREQ track-buffer requesters.
// Runs one SD transaction per grant, routes ack/buffer strobes back to the owner, and recovers from a silent host.
module ieeedrv_sd_arb #(
  parameter int NREQ      = 2,
  parameter int TIMEOUT_W = 24,
  parameter int IW        = $clog2(NREQ)
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [32*NREQ-1:0]   req_lba,
  input  logic [6*NREQ-1:0]    req_blk_cnt,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_wr,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      req_buff_wr,
  output logic [NREQ-1:0]      req_err,
  output logic [31:0]          sd_lba,
  output logic [5:0]           sd_blk_cnt,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  input  logic                 sd_buff_wr,
  output logic [IW-1:0]        grant,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_XFER,
    S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          last, last_nxt;
  logic [IW-1:0]          grant_nxt;
  logic [31:0]            lba_nxt;
  logic [5:0]             blk_nxt;
  logic                   rd_nxt, wr_nxt;
  logic [NREQ-1:0]        err_nxt;
  logic [TIMEOUT_W-1:0]   tmo_cnt, tmo_nxt, tmo_inc;
  logic [NREQ-1:0]        pending;
  logic                   owner_req;
  logic                   win_found;
  logic [IW-1:0]          winner;

  // Index reached by stepping k places past base, wrapping at NREQ.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  assign pending   = req_rd | req_wr;
  assign owner_req = pending[grant];
  assign tmo_inc   = tmo_cnt + TIMEOUT_W'(1);
  assign busy      = (state != S_IDLE);

  // Scan starts just after the last owner, so it ends up with lowest priority.
  always_comb begin
    win_found = 1'b0;
    winner    = last;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && pending[rr_idx(last, k)]) begin
        win_found = 1'b1;
        winner    = rr_idx(last, k);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    grant_nxt = grant;
    lba_nxt   = sd_lba;
    blk_nxt   = sd_blk_cnt;
    rd_nxt    = sd_rd;
    wr_nxt    = sd_wr;
    err_nxt   = '0;
    tmo_nxt   = tmo_cnt;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          grant_nxt = winner;
          last_nxt  = winner;
          lba_nxt   = req_lba[32*int'(winner) +: 32];
          blk_nxt   = req_blk_cnt[6*int'(winner) +: 6];
          wr_nxt    = req_wr[winner];
          rd_nxt    = ~req_wr[winner];
          tmo_nxt   = '0;
          state_nxt = S_ISSUE;
        end
      end
      // An ack arriving together with a dropped request still counts as started.
      S_ISSUE: begin
        tmo_nxt = tmo_inc;
        if (sd_ack) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          state_nxt = S_XFER;
        end else if (!owner_req) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          state_nxt = S_DONE;
        end else if (&tmo_inc) begin
          rd_nxt         = 1'b0;
          wr_nxt         = 1'b0;
          err_nxt[grant] = 1'b1;
          state_nxt      = S_DONE;
        end
      end
      S_XFER: begin
        if (!sd_ack) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      last       <= IW'(NREQ - 1);
      grant      <= '0;
      sd_lba     <= '0;
      sd_blk_cnt <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      req_err    <= '0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      grant      <= grant_nxt;
      sd_lba     <= lba_nxt;
      sd_blk_cnt <= blk_nxt;
      sd_rd      <= rd_nxt;
      sd_wr      <= wr_nxt;
      req_err    <= err_nxt;
      tmo_cnt    <= tmo_nxt;
    end
  end

  // Combinational return path so the owner sees ack in the same cycle as the host.
  for (genvar g = 0; g < NREQ; g++) begin : g_route
    assign req_ack[g]     = sd_ack & busy & (grant == IW'(g));
    assign req_buff_wr[g] = sd_buff_wr & (state == S_XFER) & (grant == IW'(g));
  end

endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// Testbench for ieeedrv_sd_arb: directed scenarios plus randomized traffic against a round-robin reference model.
module tb_ieeedrv_sd_arb;

  localparam int NREQ    = 4;
  localparam int TW      = 4;
  localparam int IW      = 2;
  localparam int TMO_CYC = (1 << TW) - 1;

  logic                clk_sys = 1'b0;
  logic                reset_n;
  logic [32*NREQ-1:0]  req_lba;
  logic [6*NREQ-1:0]   req_blk_cnt;
  logic [NREQ-1:0]     req_rd, req_wr;
  logic [NREQ-1:0]     req_ack, req_buff_wr, req_err;
  logic [31:0]         sd_lba;
  logic [5:0]          sd_blk_cnt;
  logic                sd_rd, sd_wr;
  logic                sd_ack, sd_buff_wr;
  logic [IW-1:0]       grant;
  logic                busy;

  int checks = 0;
  int errors = 0;

  int          mdl_last;
  logic [31:0] mdl_lba [NREQ];
  logic [5:0]  mdl_blk [NREQ];
  bit          mdl_wr  [NREQ];

  ieeedrv_sd_arb #(.NREQ(NREQ), .TIMEOUT_W(TW)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .req_lba     (req_lba),
    .req_blk_cnt (req_blk_cnt),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_ack     (req_ack),
    .req_buff_wr (req_buff_wr),
    .req_err     (req_err),
    .sd_lba      (sd_lba),
    .sd_blk_cnt  (sd_blk_cnt),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr),
    .grant       (grant),
    .busy        (busy)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Round-robin pick: rotate the pending mask so bit 0 is the requester after last.
  function automatic int rr_pick(input logic [3:0] m, input int last);
    logic [7:0] dbl;
    int r;
    dbl = {m, m} >> (last + 1);
    r = -1;
    for (int k = NREQ - 1; k >= 0; k--)
      if (dbl[k]) r = (last + 1 + k) % NREQ;
    return r;
  endfunction

  // kind: 0 read, 1 write, 2 read+write
  task automatic raise(input int i, input int kind, input logic [31:0] l, input logic [5:0] b);
    req_lba[i*32 +: 32]   = l;
    req_blk_cnt[i*6 +: 6] = b;
    req_rd[i]  = (kind != 1);
    req_wr[i]  = (kind != 0);
    mdl_lba[i] = l;
    mdl_blk[i] = b;
    mdl_wr[i]  = (kind != 0);
  endtask

  task automatic expect_start(input int w);
    step();
    check("grant", grant, w);
    check("sd_wr", sd_wr, mdl_wr[w]);
    check("sd_rd", sd_rd, !mdl_wr[w]);
    check("sd_lba", sd_lba, mdl_lba[w]);
    check("sd_blk_cnt", sd_blk_cnt, mdl_blk[w]);
    check("busy_start", busy, 1);
    check("req_err_start", req_err, 0);
  endtask

  task automatic serve(input int w, input int dly, input int acks, input int pulses, input bit rel);
    logic [31:0] held_lba, new_lba;
    logic [5:0]  held_blk;
    logic [3:0]  oh;
    int seen;
    oh       = 4'b0001 << w;
    held_lba = mdl_lba[w];
    held_blk = mdl_blk[w];
    new_lba  = $urandom;
    req_lba[w*32 +: 32] = new_lba;
    mdl_lba[w] = new_lba;
    for (int d = 0; d < dly; d++) begin
      step();
      check("issue_hold", {30'd0, sd_wr, sd_rd}, mdl_wr[w] ? 2 : 1);
    end
    seen = 0;
    for (int c = 0; c < acks; c++) begin
      sd_ack     = 1'b1;
      sd_buff_wr = (c == 0) ? 1'($urandom_range(0, 1)) : (c <= pulses);
      #1;
      check("req_ack", req_ack, oh);
      check("req_buff_wr", req_buff_wr, (c >= 1 && sd_buff_wr) ? oh : 4'b0);
      if (req_buff_wr[w]) seen++;
      step();
      if (c == 0) begin
        check("rdwr_after_ack", {30'd0, sd_wr, sd_rd}, 0);
        if (rel) begin
          req_rd[w] = 1'b0;
          req_wr[w] = 1'b0;
        end
      end
    end
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    #1;
    check("req_ack_off", req_ack, 0);
    check("buff_pulses", seen, pulses);
    step();
    check("busy_done", busy, 1);
    check("rdwr_done", {30'd0, sd_wr, sd_rd}, 0);
    check("lba_held", sd_lba, held_lba);
    check("blk_held", sd_blk_cnt, held_blk);
    check("grant_held", grant, w);
    step();
    check("busy_idle", busy, 0);
    check("rdwr_idle", {30'd0, sd_wr, sd_rd}, 0);
  endtask

  task automatic txn(input logic [3:0] arrive, input int dly, input int acks, input int pulses,
                     input bit rel, output int w);
    w = rr_pick(req_rd | req_wr, mdl_last);
    expect_start(w);
    mdl_last = w;
    for (int i = 0; i < NREQ; i++)
      if (arrive[i] && !(req_rd[i] | req_wr[i]))
        raise(i, $urandom_range(0, 2), $urandom, 6'($urandom));
    serve(w, dly, acks, pulses, rel);
  endtask

  task automatic timeout_run(input int i, input bit drop_last);
    logic [3:0] oh;
    int w;
    raise(i, 0, $urandom, 6'($urandom));
    w = rr_pick(req_rd | req_wr, mdl_last);
    oh = 4'b0001 << w;
    expect_start(w);
    mdl_last = w;
    for (int c = 1; c < TMO_CYC; c++) begin
      step();
      check("tmo_rd_hold", sd_rd, 1);
      check("tmo_no_err", req_err, 0);
    end
    if (drop_last) req_rd[w] = 1'b0;
    step();
    check("tmo_err", req_err, drop_last ? 4'b0 : oh);
    check("tmo_rdwr", {30'd0, sd_wr, sd_rd}, 0);
    check("tmo_busy", busy, 1);
    req_rd[w] = 1'b0;
    step();
    check("tmo_err_pulse", req_err, 0);
    check("tmo_idle", busy, 0);
  endtask

  initial begin
    int w, acks, guard;
    logic [3:0] m, arr;

    reset_n = 1'b0;
    req_lba = '0; req_blk_cnt = '0; req_rd = '0; req_wr = '0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    mdl_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      mdl_lba[i] = '0; mdl_blk[i] = '0; mdl_wr[i] = 1'b0;
    end
    step(); step();
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    #1;
    check("rst_sd_rd", sd_rd, 0);
    check("rst_sd_wr", sd_wr, 0);
    check("rst_sd_lba", sd_lba, 0);
    check("rst_blk", sd_blk_cnt, 0);
    check("rst_err", req_err, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_buff_wr", req_buff_wr, 0);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    reset_n = 1'b1;
    step();

    $display("[TB] contention: all four read requests");
    for (int i = 0; i < NREQ; i++) raise(i, 0, $urandom, 6'($urandom));
    for (int t = 0; t < NREQ; t++) begin
      txn(4'b0, 1, 3, 1, 1'b1, w);
      check("contention_order", w, t);
    end

    $display("[TB] single read on requester 1");
    raise(1, 0, 32'h1D, 6'd28);
    txn(4'b0, 0, 4, 3, 1'b1, w);

    $display("[TB] fairness: requester 0 keeps requesting while 2 waits");
    raise(0, 0, $urandom, 6'($urandom));
    txn(4'b0100, 0, 2, 1, 1'b0, w);
    txn(4'b0, 0, 2, 1, 1'b1, w);
    txn(4'b0, 0, 2, 1, 1'b1, w);

    $display("[TB] read+write on one requester");
    raise(1, 2, $urandom, 6'($urandom));
    txn(4'b0, 1, 2, 0, 1'b1, w);

    $display("[TB] abort on requester 3");
    raise(3, 0, $urandom, 6'($urandom));
    w = rr_pick(req_rd | req_wr, mdl_last);
    expect_start(w);
    mdl_last = w;
    repeat (4) begin
      step();
      check("abort_rd_hold", sd_rd, 1);
    end
    req_rd[3] = 1'b0;
    #1;
    check("abort_no_ack", req_ack, 0);
    step();
    check("abort_rd", sd_rd, 0);
    check("abort_no_err", req_err, 0);
    check("abort_busy", busy, 1);
    step();
    check("abort_idle", busy, 0);
    check("abort_no_err2", req_err, 0);

    $display("[TB] timeout, then abort coinciding with timeout");
    timeout_run(2, 1'b0);
    timeout_run(1, 1'b1);

    $display("[TB] ack already high when the grant is issued");
    sd_ack = 1'b1;
    #1;
    check("idle_ack_masked", req_ack, 0);
    raise(0, 1, $urandom, 6'($urandom));
    txn(4'b0, 0, 3, 2, 1'b1, w);

    $display("[TB] randomized traffic");
    for (int r = 0; r < 30; r++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++)
        if (m[i]) raise(i, $urandom_range(0, 2), $urandom, 6'($urandom));
      guard = 0;
      while ((req_rd | req_wr) != 0 && guard < 64) begin
        acks = $urandom_range(1, 5);
        arr  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
        txn(arr, $urandom_range(0, 3), acks, $urandom_range(0, acks - 1), 1'b1, w);
        guard++;
      end
    end

    $display("[TB] reset in the middle of a transfer");
    raise(2, 0, $urandom, 6'($urandom));
    w = rr_pick(req_rd | req_wr, mdl_last);
    expect_start(w);
    sd_ack = 1'b1;
    step();
    sd_buff_wr = 1'b1;
    #1;
    check("xfer_buff_wr", req_buff_wr, 4'b0001 << w);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_sd_rd", sd_rd, 0);
    check("arst_sd_wr", sd_wr, 0);
    check("arst_lba", sd_lba, 0);
    check("arst_blk", sd_blk_cnt, 0);
    check("arst_err", req_err, 0);
    check("arst_grant", grant, 0);
    check("arst_busy", busy, 0);
    check("arst_req_ack", req_ack, 0);
    check("arst_buff_wr", req_buff_wr, 0);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    req_rd = '0; req_wr = '0;
    step();
    reset_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
